// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential word fetch over a valid/ready channel,
// in-order response collection into a prefetch FIFO, and redirect flushing.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          push;
  logic          pop;

  assign occupancy      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? word_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rsp_pc   <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // outstanding covers stale and live requests alike, so every one still
        // in flight (less the one returning now) becomes stale.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: queue-based reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_addr, w_instr, w_instr_pc;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
    .imem_rsp_valid(1'b0), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] delivered[$];

  logic [31:0] m_fetch_pc;
  logic [31:0] m_fifo_pc[$];
  logic [31:0] m_infl_pc[$];
  logic        m_infl_stale[$];

  logic        s_rv, s_iv, s_wrv;
  logic [31:0] s_addr, s_instr, s_ipc, s_waddr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0000_0100;
    m_fifo_pc.delete();
    m_infl_pc.delete();
    m_infl_stale.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  // Entered at a falling edge; drives one cycle's inputs, checks, advances model.
  task automatic cycle(input logic rv, input logic [31:0] rp, input logic ir, input logic mr);
    logic        m_rv;
    logic        rsp;
    logic [31:0] pc;
    logic        st;
    redirect_valid = rv;
    redirect_pc    = rp;
    instr_ready    = ir;
    imem_req_ready = mr;
    rsp            = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rdata     = rsp ? memword(mem_addr_q[0]) : 32'hDEAD_BEEF;
    #1;
    s_rv = imem_req_valid; s_addr = imem_addr; s_iv = instr_valid;
    s_instr = instr; s_ipc = instr_pc; s_waddr = w_addr; s_wrv = w_req_valid;

    m_rv = ((m_fifo_pc.size() + m_infl_pc.size()) < int'(DEPTH)) && !rv;
    chk("req_valid", 32'(s_rv), 32'(m_rv));
    chk("imem_addr", s_addr, m_fetch_pc);
    chk("instr_valid", 32'(s_iv), 32'(m_fifo_pc.size() != 0));
    if (m_fifo_pc.size() != 0) begin
      chk("instr_pc", s_ipc, m_fifo_pc[0]);
      chk("instr", s_instr, memword(m_fifo_pc[0]));
    end

    if (s_iv && ir && !rv) delivered.push_back(s_ipc);
    if (rsp) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (s_rv && mr) begin
      mem_addr_q.push_back(s_addr);
      mem_due_q.push_back(cyc + lat);
    end

    if (rv) begin
      for (int i = 0; i < m_infl_stale.size(); i++) m_infl_stale[i] = 1'b1;
      if (rsp && m_infl_pc.size() > 0) begin
        void'(m_infl_pc.pop_front());
        void'(m_infl_stale.pop_front());
      end
      m_fifo_pc.delete();
      m_fetch_pc = {rp[31:2], 2'b00};
    end else begin
      if (m_fifo_pc.size() != 0 && ir) void'(m_fifo_pc.pop_front());
      if (rsp && m_infl_pc.size() > 0) begin
        pc = m_infl_pc.pop_front();
        st = m_infl_stale.pop_front();
        if (!st) m_fifo_pc.push_back(pc);
      end
      if (m_rv && mr) begin
        m_infl_pc.push_back(m_fetch_pc);
        m_infl_stale.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int nreq;
    int bad40;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst addr", imem_addr, 32'h0000_0100);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst wrap addr", w_addr, 32'hFFFF_FFFC);

    // Stream with 1-cycle memory.
    rst_n = 1'b1; cyc = 0; lat = 1;
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("first req", 32'(s_rv), 32'd1);
    chk("first addr", s_addr, 32'h0000_0100);
    chk("wrap first addr", s_waddr, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("second addr", s_addr, 32'h0000_0104);
    chk("no early valid", 32'(s_iv), 32'd0);
    chk("wrap second addr", s_waddr, 32'h0000_0000);
    chk("wrap second req", 32'(s_wrv), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("first valid", 32'(s_iv), 32'd1);
    chk("first instr_pc", s_ipc, 32'h0000_0100);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("second instr_pc", s_ipc, 32'h0000_0104);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);

    // Drain, then backpressure with decode stalled.
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      if (s_rv) nreq++;
    end
    chk("bp requests", 32'(nreq), 32'd4);
    chk("bp req_valid", 32'(s_rv), 32'd0);
    chk("bp head pc", s_ipc, 32'h0000_0130);
    delivered.delete();
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp pops", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < delivered.size() && i < 4; i++)
      chk("bp order", delivered[i], 32'h0000_0130 + 32'(4 * i));
    chk("bp empty", 32'(s_iv), 32'd0);

    // Redirect with 3 requests in flight, 3-cycle memory.
    lat = 3;
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_2002, 1'b1, 1'b1);
    chk("redir cycle req", 32'(s_rv), 32'd0);
    delivered.delete();
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("redir new addr", s_addr, 32'h0000_2000);
    chk("redir new req", 32'(s_rv), 32'd1);
    chk("redir iv", 32'(s_iv), 32'd0);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
    chk("redir delivered", 32'(delivered.size() > 0), 32'd1);
    if (delivered.size() > 0) chk("redir first pc", delivered[0], 32'h0000_2000);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);

    // Redirect coinciding with a response and a pop, FIFO count 2, 2-cycle memory.
    lat = 2;
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    chk("rp pre iv", 32'(s_iv), 32'd1);
    delivered.delete();
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("rp flushed", 32'(s_iv), 32'd0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    chk("rp delivered", 32'(delivered.size() > 0), 32'd1);
    if (delivered.size() > 0) chk("rp first pc", delivered[0], 32'h0000_0300);

    // Back-to-back redirects.
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    chk("b2b req 1", 32'(s_rv), 32'd0);
    cycle(1'b1, 32'h0000_0080, 1'b1, 1'b1);
    chk("b2b req 2", 32'(s_rv), 32'd0);
    delivered.delete();
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("b2b addr", s_addr, 32'h0000_0080);
    repeat (15) cycle(1'b0, '0, 1'b1, 1'b1);
    bad40 = 0;
    foreach (delivered[i]) if (delivered[i] >= 32'h40 && delivered[i] < 32'h80) bad40++;
    chk("b2b no 0x40", 32'(bad40), 32'd0);
    chk("b2b delivered", 32'(delivered.size() > 0), 32'd1);
    if (delivered.size() > 0) chk("b2b first pc", delivered[0], 32'h0000_0080);

    // Fill the FIFO, then assert reset between clock edges.
    lat = 1;
    repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("full iv", 32'(s_iv), 32'd1);
    chk("full req", 32'(s_rv), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async req_valid", 32'(imem_req_valid), 32'd0);
    chk("async instr_valid", 32'(instr_valid), 32'd0);
    imem_rsp_valid = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("post reset addr", s_addr, 32'h0000_0100);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
